// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the M-extension EX-stage sequencer: ALU op codes, FSM states, op-class helpers.
package muldiv_sequencer_pkg;

   localparam int unsigned ALUOP_W     = 5;
   localparam int unsigned OP_SEL_W    = 3;
   localparam int unsigned STALL_CNT_W = 32;

   localparam logic [ALUOP_W-1:0] ALU_MUL    = 5'b01011;
   localparam logic [ALUOP_W-1:0] ALU_MULH   = 5'b01100;
   localparam logic [ALUOP_W-1:0] ALU_MULHSU = 5'b01101;
   localparam logic [ALUOP_W-1:0] ALU_MULHU  = 5'b01110;
   localparam logic [ALUOP_W-1:0] ALU_DIV    = 5'b01111;
   localparam logic [ALUOP_W-1:0] ALU_DIVU   = 5'b10000;
   localparam logic [ALUOP_W-1:0] ALU_REM    = 5'b10001;
   localparam logic [ALUOP_W-1:0] ALU_REMU   = 5'b10010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   function automatic logic is_md(input logic [ALUOP_W-1:0] op);
      return (op >= ALU_MUL) && (op <= ALU_REMU);
   endfunction

   function automatic logic is_div(input logic [ALUOP_W-1:0] op);
      return (op >= ALU_DIV) && (op <= ALU_REMU);
   endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// EX-stage controller for the iterative mul/div datapath: launches on an M-op,
// stalls the front of the pipe until the result is ready, aborts on flush.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 32,
   parameter int unsigned CNT_W      = 6
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [ALUOP_W-1:0]     ALUOP,
   input  logic                   VALID,
   input  logic                   FLUSH,
   input  logic                   DIVISOR_ZERO,
   output logic                   STALL,
   output logic                   START,
   output logic                   STEP,
   output logic [OP_SEL_W-1:0]    OP_SEL,
   output logic                   RESULT_VALID,
   output logic [STALL_CNT_W-1:0] STALL_COUNT
);

   localparam logic [CNT_W-1:0] MUL_LAT_M1 = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAT_M1 = CNT_W'(DIV_CYCLES - 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             launch;
   logic             op_div;

   assign launch = (state_q == ST_IDLE) && VALID && is_md(ALUOP) && !FLUSH;
   assign op_div = is_div(ALUOP);

   // Next state, iteration counter and per-cycle control strobes.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      STALL        = 1'b0;
      START        = 1'b0;
      STEP         = 1'b0;
      RESULT_VALID = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (launch) begin
               START = 1'b1;
               STALL = 1'b1;
               if (op_div && DIVISOR_ZERO) begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_RUN;
                  cnt_d   = op_div ? DIV_LAT_M1 : MUL_LAT_M1;
               end
            end
         end
         ST_RUN: begin
            if (FLUSH) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               STEP  = 1'b1;
               STALL = 1'b1;
               if (cnt_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            // Always return to IDLE so the completed instruction is not reissued.
            state_d      = ST_IDLE;
            RESULT_VALID = !FLUSH;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         OP_SEL      <= '0;
         STALL_COUNT <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         STALL_COUNT <= STALL_COUNT + STALL_CNT_W'(STALL);
         if (launch) begin
            OP_SEL <= OP_SEL_W'(ALUOP - ALU_MUL);
         end
      end
   end

endmodule
